// File: rtl/detect_window_counter_pkg.sv
// Shared definitions for the 1-then-0 detector and its window counter.
package det_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_THRESH  = 4;

endpackage

// File: rtl/detect_window_counter_if.sv
// Detection input, control and result port bundle for detect_window_counter.
interface detect_window_counter_if #(
  parameter int WC_W  = 5,
  parameter int TOT_W = 16
);
  logic             det;
  logic             en;
  logic             clear;
  logic             res_ready;
  logic             res_valid;
  logic [WC_W-1:0]  res_data;
  logic [TOT_W-1:0] total;
  logic             alarm;
  logic             ovf;
  logic             busy;

  modport master (
    output det, en, clear, res_ready,
    input  res_valid, res_data, total, alarm, ovf, busy
  );

  modport slave (
    input  det, en, clear, res_ready,
    output res_valid, res_data, total, alarm, ovf, busy
  );
endinterface

// File: rtl/detect_window_counter_sat_counter.sv
// Up-counter that sticks at all-ones; clr takes priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/detect_window_counter.sv
// Counts detector hits over back-to-back WIN_LEN-cycle windows. States:
// S_IDLE | det ignored, counters hold ; S_COUNT | window running, busy=1
module detect_window_counter
  import det_pkg::*;
#(
  parameter  int WIN_LEN = DEF_WIN_LEN,
  parameter  int THRESH  = DEF_THRESH,
  parameter  int TOT_W   = 16,
  localparam int WC_W    = $clog2(WIN_LEN + 1)
) (
  input logic                    clk,
  input logic                    rst,
  detect_window_counter_if.slave bus
);

  localparam int               CYC_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WIN_LEN - 1);
  localparam logic [WC_W-1:0]  THRESH_C = WC_W'(THRESH);

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [WC_W-1:0]  win_q, win_d, win_sum;
  logic [WC_W-1:0]  res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q, ovf_d;
  logic             counting, abort, win_close, total_inc, busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.en)  state_d = S_COUNT;
        S_COUNT: if (!bus.en) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == S_COUNT);
    counting  = busy && bus.en;
    abort     = busy && !bus.en;
    win_close = counting && (cyc_q == CYC_LAST);
    // last-cycle detection folds into the closing count
    win_sum   = win_q + WC_W'(bus.det);
    total_inc = busy && bus.det;
  end

  always_comb begin
    cyc_d       = cyc_q;
    win_d       = win_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    alarm_d     = alarm_q;
    ovf_d       = ovf_q;
    if (bus.clear) begin
      cyc_d       = '0;
      win_d       = '0;
      res_data_d  = '0;
      res_valid_d = 1'b0;
      alarm_d     = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      if (win_close || abort) begin
        cyc_d = '0;
        win_d = '0;
      end else if (counting) begin
        cyc_d = cyc_q + CYC_W'(1);
        win_d = win_sum;
      end
      // a close coinciding with a transfer refills the slot without overrun
      if (win_close) begin
        res_data_d  = win_sum;
        res_valid_d = 1'b1;
        if (res_valid_q && !bus.res_ready) ovf_d = 1'b1;
        if (win_sum >= THRESH_C)           alarm_d = 1'b1;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q       <= '0;
      win_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      win_q       <= win_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      alarm_q     <= alarm_d;
      ovf_q       <= ovf_d;
    end
  end

  sat_counter #(.W(TOT_W)) u_total (
    .clk   (clk),
    .rst   (rst),
    .inc   (total_inc),
    .clr   (bus.clear),
    .count (bus.total)
  );

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.alarm     = alarm_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_detect_window_counter.sv
// Directed bench for detect_window_counter: results checked by a queue-fed monitor, flags checked inline.
module tb_detect_window_counter;

  localparam int WIN_LEN = 8;
  localparam int THRESH  = 3;
  localparam int TOT_W   = 4;
  localparam int WC_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  detect_window_counter_if #(.WC_W(WC_W), .TOT_W(TOT_W)) bus ();

  detect_window_counter #(
    .WIN_LEN (WIN_LEN),
    .THRESH  (THRESH),
    .TOT_W   (TOT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WC_W-1:0] data;
    logic            alarm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int data, input logic alarm);
    exp_t e;
    e.data  = WC_W'(data);
    e.alarm = alarm;
    exp_q.push_back(e);
  endtask

  // inputs change 1 time unit after each rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    bus.en    = 1'b0;
    bus.det   = 1'b0;
    cyc();
    bus.clear = 1'b0;
  endtask

  task automatic start();
    bus.en  = 1'b1;
    bus.det = 1'b0;
    cyc();
  endtask

  task automatic window(input logic [7:0] pat, input logic ready_last);
    for (int i = 0; i < WIN_LEN; i++) begin
      bus.det = pat[i];
      if (i == WIN_LEN - 1 && ready_last) bus.res_ready = 1'b1;
      cyc();
    end
    bus.det = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input int valid, input int data,
                             input int total, input int alarm, input int ovf, input int busy);
    chk({tag, "_valid"}, 32'(bus.res_valid), valid);
    chk({tag, "_data"},  32'(bus.res_data),  data);
    chk({tag, "_total"}, 32'(bus.total),     total);
    chk({tag, "_alarm"}, 32'(bus.alarm),     alarm);
    chk({tag, "_ovf"},   32'(bus.ovf),       ovf);
    chk({tag, "_busy"},  32'(bus.busy),      busy);
  endtask

  // Monitor: every accepted result must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data %0d expected no result", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          chk("result_data",  32'(bus.res_data), 32'(e.data));
          chk("result_alarm", 32'(bus.alarm),    32'(e.alarm));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.det       = 1'b0;
    bus.en        = 1'b0;
    bus.clear     = 1'b0;
    bus.res_ready = 1'b1;
    #3;
    chk_outputs("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    // basic window: 3 hits, alarm, one-cycle valid pulse
    push_exp(3, 1'b1);
    start();
    chk("start_busy", 32'(bus.busy), 1);
    window(8'b1000_1010, 1'b0);
    chk_outputs("basic", 1, 3, 3, 1, 0, 1);
    bus.en = 1'b0;
    cyc();
    chk("basic_pulse_valid", 32'(bus.res_valid), 0);
    chk("basic_idle_busy",   32'(bus.busy),      0);

    // only the last cycle detects
    do_clear();
    push_exp(1, 1'b0);
    start();
    window(8'b1000_0000, 1'b0);
    chk_outputs("last", 1, 1, 1, 0, 0, 1);
    bus.en = 1'b0;
    cyc();

    // overrun, then accept on the close edge of a third window
    do_clear();
    bus.res_ready = 1'b0;
    start();
    window(8'b0000_0011, 1'b0);
    chk_outputs("ovr_a", 1, 2, 2, 0, 0, 1);
    window(8'b0001_0000, 1'b0);
    chk_outputs("ovr_b", 1, 1, 3, 0, 1, 1);
    push_exp(1, 1'b0);
    window(8'b0100_0101, 1'b1);
    chk_outputs("ovr_c", 1, 3, 6, 1, 1, 1);
    push_exp(3, 1'b1);
    bus.en = 1'b0;
    cyc();
    chk("ovr_drain_valid", 32'(bus.res_valid), 0);

    // accept on close edge with no prior overrun must leave ovf clear
    do_clear();
    bus.res_ready = 1'b0;
    start();
    window(8'b0000_0011, 1'b0);
    push_exp(2, 1'b0);
    window(8'b1000_0001, 1'b1);
    chk_outputs("accept_close", 1, 2, 4, 0, 0, 1);
    push_exp(2, 1'b0);
    bus.en = 1'b0;
    cyc();

    // abort after 5 cycles holding 2 detections
    do_clear();
    bus.res_ready = 1'b1;
    start();
    for (int i = 0; i < 5; i++) begin
      bus.det = (i == 1 || i == 3);
      cyc();
    end
    bus.det = 1'b0;
    bus.en  = 1'b0;
    cyc();
    chk_outputs("abort", 0, 0, 2, 0, 0, 0);
    bus.det = 1'b1;
    cyc();
    cyc();
    chk("abort_idle_total", 32'(bus.total), 2);
    push_exp(1, 1'b0);
    bus.en  = 1'b1;
    bus.det = 1'b1;
    cyc();
    window(8'b0000_0001, 1'b0);
    chk_outputs("abort_fresh", 1, 1, 3, 0, 0, 1);
    bus.en = 1'b0;
    cyc();

    // saturation of total, then clear on a window-close edge
    do_clear();
    for (int w = 0; w < 5; w++) push_exp(4, 1'b1);
    start();
    for (int i = 0; i < 47; i++) begin
      bus.det = i[0];
      cyc();
      if (i == 39) chk("sat_total_reached", 32'(bus.total), 15);
      if (i == 44) chk("sat_total_held",    32'(bus.total), 15);
    end
    bus.det   = 1'b1;
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    bus.en    = 1'b0;
    bus.det   = 1'b0;
    chk_outputs("clear_close", 0, 0, 0, 0, 0, 0);
    cyc();
    chk("clear_stays_valid", 32'(bus.res_valid), 0);

    // asynchronous reset mid-window with a pending result
    bus.res_ready = 1'b0;
    start();
    window(8'b0000_0111, 1'b0);
    chk_outputs("pre_rst", 1, 3, 3, 1, 0, 1);
    bus.det = 1'b1;
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk_outputs("async_rst", 0, 0, 0, 0, 0, 0);
    bus.en  = 1'b0;
    bus.det = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_window_counter.md
# detect_window_counter

Downstream consumer of the "1-then-0" sequence detector. It samples the detector's one-cycle detection flag every clock and counts detections over fixed, back-to-back windows of `WIN_LEN` cycles. Each closed window's count is offered on a valid/ready result port. It also keeps a saturating lifetime total, a sticky threshold alarm and a sticky result-overrun flag.

## Interface
- `WIN_LEN`, default 16: window length in clock cycles, ≥ 2.
- `THRESH`, default 4: window count at or above which `alarm` sets, 1..`WIN_LEN`.
- `TOT_W`, default 16: width of the lifetime total.
- `WC_W`, derived, equals `$clog2(WIN_LEN+1)`: width of window count and result.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `det` in 1: detection flag from the detector (its `z`), sampled every edge.
- `en` in 1: run enable.
- `clear` in 1: synchronous clear, highest priority after `rst`.
- `res_valid` out 1: window result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out `WC_W`: detections in the completed window.
- `total` out `TOT_W`: saturating count of all detections taken while in COUNT.
- `alarm` out 1: sticky; a window reached `THRESH`.
- `ovf` out 1: sticky; an unaccepted result was overwritten.
- `busy` out 1: high in COUNT.

## Operation
- The state machine has two states:
  - IDLE (reset state): `det` is ignored and all counters hold. Goes to COUNT when `en`=1.
  - COUNT: on each edge, `cyc` (0..`WIN_LEN`-1) increments and `win` increments when `det`=1. Goes to IDLE when `en`=0.
- Abort: leaving COUNT via `en`=0 discards the partial window.
  - `cyc` and `win` clear to 0 and no result is produced.
  - A pending result is kept.
- Window close: happens in COUNT when `cyc`==`WIN_LEN`-1 and `en`=1.
  - `res_data` ← `win`+`det`, so the last cycle's detection is included.
  - `res_valid` ← 1.
  - `win` ← 0 and `cyc` ← 0.
  - `alarm` ← 1 if `win`+`det` ≥ `THRESH`.
- Overrun: set `ovf` ← 1 if a window closes while `res_valid`=1 and `res_ready`=0. The new result overwrites the old one.
- Handshake: a transfer happens on an edge where `res_valid`=1 and `res_ready`=1. After a transfer, `res_valid` ← 0, unless a window closes on the same edge.
  - In that case `res_valid` stays 1 with the new data, and `ovf` is not set.
- `res_data` is stable while `res_valid`=1 and no window closes.
- `total` increments on each `det`=1 edge in COUNT and saturates at 2^`TOT_W`-1.
- `win` cannot exceed `WIN_LEN`, so `WC_W` never overflows.
- `clear`=1 applies on the next edge:
  - state → IDLE;
  - `cyc`, `win`, `total`, `res_data` ← 0;
  - `res_valid`, `alarm`, `ovf` ← 0.
  - `clear` overrides `en`, a window close and the handshake on that edge.
- `rst` low gives the same values as `clear`, applied asynchronously.

## Timing
- Reset values: `res_valid`=0, `res_data`=0, `total`=0, `alarm`=0, `ovf`=0, `busy`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Going active:
  - `en` rises before edge E0: COUNT is entered at E0 and `busy`=1 after E0.
  - `det` is first counted at edge E1.
  - The window spans edges E1..E`WIN_LEN`.
  - `res_valid` rises right after edge E`WIN_LEN`.
- Steady state: results come every `WIN_LEN` cycles, with no dead cycle between windows.
- `det` with `en`=1 on the very edge that leaves IDLE is not counted.
- Release of `rst` should be synchronous to `clk`. The block does not resynchronize it.

## Structure
- A shared package `det_pkg` holds:
  - state encoding (`S_IDLE`=1'b0, `S_COUNT`=1'b1);
  - default `WIN_LEN`/`THRESH` constants, shared with the detector bench.
- Sub-module `sat_counter`, parameterized by width, with `inc`, `clr` and a saturating count output.
  - It is used for `total`.
  - `win` uses a plain counter, since it cannot overflow.
- Everything else lives in one module: state register, window logic, result register and flags.

## Test plan
All scenarios use `WIN_LEN`=8, `THRESH`=3, `TOT_W`=4.
- Basic window:
  - Stimulus: `en`=1, `res_ready`=1, `det` pattern 0,1,0,1,0,0,0,1 over edges E1..E8.
  - Response: `res_valid` pulses one cycle after E8 with `res_data`=3, `alarm`=1, `total`=3, `ovf`=0.
- Last-cycle detection and low count:
  - Stimulus: `det`=1 only on E8.
  - Response: `res_data`=1, `alarm` stays 0.
- Overrun:
  - Stimulus: `res_ready`=0 for two full windows with counts 2 then 1.
  - Response: `ovf`=1 after the second close, `res_data`=1, `res_valid` held.
  - Accept with `res_ready`=1 on the close edge of the third window: `res_valid` stays 1 with the new count and `ovf` does not re-trigger.
- Abort mid-window:
  - Stimulus: `en`=0 after 5 cycles holding 2 detections, then `en`=1 again.
  - Response: no result from the aborted window; the next result covers only the fresh 8 cycles; `total` includes all 2 earlier detections.
- Saturation and clear:
  - Stimulus: 20 detections with `det` alternating.
  - Response: `total`=15 and held.
  - Then `clear`=1 together with a window-close edge: all outputs read 0 on the next cycle, with `res_valid`=0 and state IDLE.
- Async reset:
  - Stimulus: `rst` low mid-window, with `res_valid`=1.
  - Response: outputs go to reset values immediately, without waiting for `clk`.
